// File: rtl/digit_entry_loader_pkg.sv
// Shared types and limits for the keypad digit-entry loader.
package digit_entry_loader_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned MAX_DIGITS   = 3;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned DIGIT_MAX    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2,
        ST_COOK  = 2'd3
    } state_e;

endpackage

// File: rtl/digit_entry_loader_bcd_shift3.sv
// Three-digit BCD shift buffer (min / sec tens / sec ones) with digit count
// and the legality check for the next shifted-in key.
module bcd_shift3
    import digit_entry_loader_pkg::*;
(
    input  logic               clock,
    input  logic               clrn,
    input  logic               push_i,
    input  logic               clear_i,
    input  logic [DIGIT_W-1:0] code_i,
    output logic               legal_c_o,
    output logic [DIGIT_W-1:0] min_o,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o,
    output logic [CNT_W-1:0]   digits_o
);

    logic [DIGIT_W-1:0] min_q,  min_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0]   digits_q, digits_d;

    // The current ones digit becomes the seconds-tens digit after a shift.
    assign legal_c_o = (code_i <= DIGIT_W'(DIGIT_MAX))
                    && (digits_q < CNT_W'(MAX_DIGITS))
                    && (ones_q <= DIGIT_W'(SEC_TENS_MAX));

    always_comb begin
        min_d    = min_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        digits_d = digits_q;
        if (clear_i) begin
            min_d    = '0;
            tens_d   = '0;
            ones_d   = '0;
            digits_d = '0;
        end else if (push_i && legal_c_o) begin
            min_d    = tens_q;
            tens_d   = ones_q;
            ones_d   = code_i;
            digits_d = digits_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            min_q    <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            digits_q <= '0;
        end else begin
            min_q    <= min_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            digits_q <= digits_d;
        end
    end

    assign min_o    = min_q;
    assign tens_o   = tens_q;
    assign ones_o   = ones_q;
    assign digits_o = digits_q;

endmodule

// File: rtl/digit_entry_loader.sv
// Keypad time-entry controller: collects up to three BCD digits, loads them
// into the downstream counters on start, and enables counting until done.
module digit_entry_loader
    import digit_entry_loader_pkg::*;
(
    input  logic               clock,
    input  logic               clrn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_start,
    input  logic               key_clear,
    input  logic               timer_done,
    output logic [DIGIT_W-1:0] min_d,
    output logic [DIGIT_W-1:0] sec_tens_d,
    output logic [DIGIT_W-1:0] sec_ones_d,
    output logic               loadn,
    output logic               cnt_clrn,
    output logic               en,
    output logic [CNT_W-1:0]   digits,
    output logic               key_err,
    output logic               done
);

    state_e state_q;
    logic   loadn_q, cnt_clrn_q, en_q, done_q, key_err_q;
    logic   push_c, clear_c, legal_c;

    // Start outranks a digit only where start actually does something (ENTRY).
    assign push_c  = key_valid && !key_clear
                  && ((state_q == ST_IDLE) || ((state_q == ST_ENTRY) && !key_start));
    assign clear_c = key_clear || ((state_q == ST_COOK) && timer_done);

    bcd_shift3 u_buf (
        .clock     (clock),
        .clrn      (clrn),
        .push_i    (push_c),
        .clear_i   (clear_c),
        .code_i    (key_code),
        .legal_c_o (legal_c),
        .min_o     (min_d),
        .tens_o    (sec_tens_d),
        .ones_o    (sec_ones_d),
        .digits_o  (digits)
    );

    always_ff @(posedge clock) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;
            done_q     <= 1'b0;
            key_err_q  <= 1'b0;
            if (key_clear) begin
                state_q    <= ST_IDLE;
                cnt_clrn_q <= 1'b0;
                en_q       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_ENTRY: begin
                        if (key_start && (state_q == ST_ENTRY)) begin
                            state_q <= ST_LOAD;
                            loadn_q <= 1'b0;
                        end else if (key_valid) begin
                            if (legal_c) state_q   <= ST_ENTRY;
                            else         key_err_q <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_COOK;
                        en_q    <= 1'b1;
                    end
                    ST_COOK: begin
                        if (timer_done) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            en_q    <= 1'b0;
                        end else begin
                            en_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign loadn    = loadn_q;
    assign cnt_clrn = cnt_clrn_q;
    assign en       = en_q;
    assign done     = done_q;
    assign key_err  = key_err_q;

endmodule

// File: tb/tb_digit_entry_loader.sv
// Scoreboard bench for digit_entry_loader: stimulus queues expected output
// events; a monitor pops one whenever a strobe fires or en/digits change.
module tb_digit_entry_loader;

    typedef struct packed {
        logic       loadn;
        logic       cnt_clrn;
        logic       done;
        logic       key_err;
        logic       en;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic [1:0] d;
    } snap_t;

    logic       clock = 1'b0;
    logic       clrn;
    logic       key_valid, key_start, key_clear, timer_done;
    logic [3:0] key_code;
    logic [3:0] min_d, sec_tens_d, sec_ones_d;
    logic       loadn, cnt_clrn, en, key_err, done;
    logic [1:0] digits;

    snap_t exp_q[$];
    int    vectors    = 0;
    int    miscompares = 0;
    bit    end_req    = 1'b0;

    digit_entry_loader dut (
        .clock      (clock),
        .clrn       (clrn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_start  (key_start),
        .key_clear  (key_clear),
        .timer_done (timer_done),
        .min_d      (min_d),
        .sec_tens_d (sec_tens_d),
        .sec_ones_d (sec_ones_d),
        .loadn      (loadn),
        .cnt_clrn   (cnt_clrn),
        .en         (en),
        .digits     (digits),
        .key_err    (key_err),
        .done       (done)
    );

    always #5 clock = ~clock;

    function automatic snap_t ev(input logic ld, input logic cc, input logic dn,
                                 input logic er, input logic e, input logic [3:0] m,
                                 input logic [3:0] t, input logic [3:0] o, input logic [1:0] d);
        snap_t s;
        s.loadn = ld; s.cnt_clrn = cc; s.done = dn; s.key_err = er; s.en = e;
        s.m = m; s.t = t; s.o = o; s.d = d;
        return s;
    endfunction

    // Buffer-only event: no strobes other than an optional key_err, en low.
    function automatic snap_t evb(input logic er, input logic [3:0] m, input logic [3:0] t,
                                  input logic [3:0] o, input logic [1:0] d);
        return ev(1'b1, 1'b1, 1'b0, er, 1'b0, m, t, o, d);
    endfunction

    task automatic expect_ev(input snap_t s);
        exp_q.push_back(s);
    endtask

    task automatic drive(input logic kv, input logic [3:0] kc, input logic ks,
                         input logic kcl, input logic td);
        key_valid = kv; key_code = kc; key_start = ks; key_clear = kcl; timer_done = td;
        @(negedge clock);
        key_valid = 1'b0; key_code = 4'd0; key_start = 1'b0; key_clear = 1'b0; timer_done = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] c);
        drive(1'b1, c, 1'b0, 1'b0, 1'b0);
    endtask

    // Stimulus
    initial begin
        clrn = 1'b0;
        key_valid = 1'b0; key_code = 4'd0; key_start = 1'b0; key_clear = 1'b0; timer_done = 1'b0;
        repeat (3) expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clock);
        clrn = 1'b1;
        idle();

        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);      // start in IDLE: silent

        expect_ev(evb(0, 0, 0, 1, 1)); key(4'd1);
        expect_ev(evb(0, 0, 1, 3, 2)); key(4'd3);
        expect_ev(evb(0, 1, 3, 0, 3)); key(4'd0);
        expect_ev(ev(0, 1, 0, 0, 0, 1, 3, 0, 3));
        expect_ev(ev(1, 1, 0, 0, 1, 1, 3, 0, 3));
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle();

        key(4'd5);                                  // COOK ignores keys and start
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        key(4'hC);
        expect_ev(ev(1, 1, 1, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(); idle();

        expect_ev(evb(0, 0, 0, 7, 1)); key(4'd7);
        expect_ev(evb(1, 0, 0, 7, 1)); key(4'd0);
        idle();
        expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();

        expect_ev(evb(0, 0, 0, 1, 1)); key(4'd1);
        expect_ev(evb(0, 0, 1, 2, 2)); key(4'd2);
        expect_ev(evb(0, 1, 2, 3, 3)); key(4'd3);
        expect_ev(evb(1, 1, 2, 3, 3)); key(4'd4);
        idle();
        expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));  // clear beats start
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(); idle();

        expect_ev(evb(0, 0, 0, 5, 1)); key(4'd5);
        expect_ev(evb(0, 0, 5, 9, 2)); key(4'd9);
        expect_ev(evb(1, 0, 5, 9, 2)); key(4'd6);   // 9 would land in sec tens
        idle();
        expect_ev(evb(1, 0, 5, 9, 2)); key(4'd10);
        idle();
        expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();

        expect_ev(evb(0, 0, 0, 5, 1)); key(4'd5);
        expect_ev(ev(0, 1, 0, 0, 0, 0, 0, 5, 1));
        expect_ev(ev(1, 1, 0, 0, 1, 0, 0, 5, 1));
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle();
        expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));  // clear beats timer_done
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(); idle();

        expect_ev(evb(0, 0, 0, 2, 1)); key(4'd2);
        expect_ev(ev(0, 1, 0, 0, 0, 0, 0, 2, 1));
        expect_ev(ev(1, 1, 0, 0, 1, 0, 0, 2, 1));
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(); idle();
        expect_ev(ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
        clrn = 1'b0; key_start = 1'b1; timer_done = 1'b1;
        @(negedge clock);
        clrn = 1'b1; key_start = 1'b0; timer_done = 1'b0;
        idle(); idle(); idle();

        end_req = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        snap_t cur, exp_s;
        logic  prev_en = 1'b0;
        logic [1:0] prev_d = 2'd0;
        bit    trig;
        while (!end_req) begin
            @(negedge clock);
            cur  = ev(loadn, cnt_clrn, done, key_err, en, min_d, sec_tens_d, sec_ones_d, digits);
            trig = (loadn !== 1'b1) || (cnt_clrn !== 1'b1) || (done !== 1'b0)
                || (key_err !== 1'b0) || (en !== prev_en) || (digits !== prev_d);
            prev_en = en;
            prev_d  = digits;
            if (trig) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event t=%0t: got loadn=%b cnt_clrn=%b done=%b key_err=%b en=%b buf=%0d/%0d/%0d digits=%0d, required no event",
                             $time, cur.loadn, cur.cnt_clrn, cur.done, cur.key_err, cur.en, cur.m, cur.t, cur.o, cur.d);
                end else begin
                    exp_s = exp_q.pop_front();
                    if (cur !== exp_s) begin
                        miscompares++;
                        $display("FAIL event%0d t=%0t: got loadn=%b cnt_clrn=%b done=%b key_err=%b en=%b buf=%0d/%0d/%0d digits=%0d, required loadn=%b cnt_clrn=%b done=%b key_err=%b en=%b buf=%0d/%0d/%0d digits=%0d",
                                 vectors, $time, cur.loadn, cur.cnt_clrn, cur.done, cur.key_err, cur.en, cur.m, cur.t, cur.o, cur.d,
                                 exp_s.loadn, exp_s.cnt_clrn, exp_s.done, exp_s.key_err, exp_s.en, exp_s.m, exp_s.t, exp_s.o, exp_s.d);
                    end
                end
            end
        end
        while (exp_q.size() != 0) begin
            exp_s = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got none, required loadn=%b cnt_clrn=%b done=%b key_err=%b en=%b buf=%0d/%0d/%0d digits=%0d",
                     exp_s.loadn, exp_s.cnt_clrn, exp_s.done, exp_s.key_err, exp_s.en, exp_s.m, exp_s.t, exp_s.o, exp_s.d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
